mac_axil_config: RTL and testbench
==================================

MAC_AXIL_CONFIG -- requirements
Module: mac_axil_config

Interface
REQ-001 The module SHALL have parameter STARTUP_CYCLES, default 1000, giving the wait in s_axi_clk cycles after PHY release before the first write.
REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the maximum cycles any single AXI-lite transaction may take.
REQ-003 The ports SHALL be as follows (name, direction, width, meaning):
- s_axi_clk  in  1  sole clock, 200 MHz.
- s_axi_resetn  in  1  reset, synchronous to s_axi_clk, active-low.
- phy_resetn  in  1  PHY reset state from the eth_gtx_clk domain; high means released.
- speed_sel  in  2  MAC speed code: 00 = 10M, 01 = 100M, 10 = 1G.
- m_axi_awaddr  out  12  write address.
- m_axi_awvalid  out  1  write address valid.
- m_axi_awready  in  1  write address ready.
- m_axi_wdata  out  32  write data.
- m_axi_wvalid  out  1  write data valid.
- m_axi_wready  in  1  write data ready.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  write response ready.
- m_axi_araddr  out  12  read address.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_rdata  in  32  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.
- cfg_done  out  1  configuration complete and verified.
- cfg_error  out  1  configuration failed; sticky until re-run.

Function
REQ-004 phy_resetn SHALL pass through a 2-flop synchronizer into s_axi_clk before use; the synchronized signal is phy_rel.
REQ-005 The FSM SHALL have these states: IDLE, STARTUP, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE, ERROR.
REQ-006 IDLE -> STARTUP SHALL occur when phy_rel = 1; STARTUP SHALL count STARTUP_CYCLES cycles and then enter WR_REQ with index 0.
REQ-007 speed_sel SHALL be captured into an internal register on the STARTUP -> WR_REQ transition.
REQ-008 The write table SHALL be executed in this order:
- 0x500 <= 0x0000_0068 (MDIO enable, clock divide)
- 0x404 <= 0x1000_0000 (RX enable)
- 0x408 <= 0x1000_0000 (TX enable)
- 0x40C <= 0x0000_0000 (flow control off)
- 0x410 <= {speed_reg, 30'b0}
REQ-009 WR_REQ SHALL assert awvalid and wvalid together; each SHALL drop independently the cycle after its own valid&ready handshake.
REQ-010 WR_REQ SHALL go to WR_RESP once both handshakes have completed, with either completing first or both completing in the same cycle.
REQ-011 Address and data outputs SHALL be stable while the corresponding valid is high; a valid SHALL never be withdrawn before its handshake.
REQ-012 WR_RESP SHALL hold bready = 1; on bvalid with bresp = 00 it SHALL advance to the next write, or to RD_REQ after entry 4; any other bresp SHALL go to ERROR.
REQ-013 RD_REQ SHALL assert arvalid with araddr = 0x410 until arready; RD_RESP SHALL hold rready = 1.
REQ-014 On rvalid, RD_RESP SHALL go to DONE if rresp = 00 and rdata[31:30] = speed_reg; otherwise it SHALL go to ERROR.
REQ-015 A per-transaction timer SHALL clear on entry to WR_REQ or RD_REQ; reaching TIMEOUT_CYCLES before the closing response SHALL go to ERROR.
REQ-016 On a timeout, any still-asserted valids SHALL be deasserted in ERROR; this deviation from AXI is accepted for fault handling only.
REQ-017 In DONE, cfg_done SHALL be 1; a change of speed_sel away from speed_reg SHALL recapture speed_reg, clear cfg_done, and re-run entry 4 plus the read-back.
REQ-018 In ERROR, cfg_error SHALL be 1 and cfg_done SHALL be 0.
REQ-019 phy_rel = 0 while in DONE or ERROR SHALL clear both flags and return to IDLE.
REQ-020 phy_rel = 0 in any other state SHALL be ignored until DONE or ERROR is reached.
REQ-021 All outputs SHALL be registered, and there SHALL be no combinational path from input to output.

Reset
REQ-022 On s_axi_resetn = 0 at a clock edge, the FSM SHALL enter IDLE and the counters, index and synchronizer SHALL clear.
REQ-023 On reset, all valid/ready outputs, cfg_done and cfg_error SHALL be 0, and the address/data outputs SHALL be 0.
REQ-024 A reset mid-transaction SHALL abort immediately, and the full sequence SHALL restart from IDLE afterwards.

Structure
REQ-025 The register addresses, write-table values, state encodings and the OKAY code SHALL live in a shared package, mac_cfg_pkg.
REQ-026 The phy_resetn synchronizer SHALL be an instance of the existing syn_block, with enable tied to 1.
REQ-027 No other sub-modules SHALL be used.

Verification
REQ-028 Zero-wait slave, phy_resetn rising, speed_sel = 10: the bench SHALL see 5 writes in order, with 0x410 written as 0x8000_0000, a read-back of 0x8000_0000, and cfg_done = 1.
REQ-029 awready delayed 3 cycles while wready is immediate: wvalid SHALL drop after 1 cycle, awvalid SHALL be held with a stable address, and exactly 5 B handshakes SHALL occur.
REQ-030 bresp = 10 on write 2 (0x404): the FSM SHALL enter ERROR, cfg_error SHALL be 1, and no write to 0x408 SHALL occur.
REQ-031 Slave never asserts arready: cfg_error SHALL go to 1 exactly TIMEOUT_CYCLES cycles after arvalid rises, with arvalid = 0 afterwards.
REQ-032 In DONE, speed_sel changes 10 -> 01: the bench SHALL see one write of 0x410 = 0x4000_0000 and one read, with cfg_done low during the re-run and then 1.
REQ-033 s_axi_resetn pulsed low during write 3: all outputs SHALL be 0 on the next cycle, and after release the sequence SHALL restart at 0x500 following STARTUP_CYCLES.

Source files
------------

// File: rtl/mac_cfg_pkg.sv
// Shared constants for the MAC AXI-lite configuration sequencer: register map,
// write-table contents, FSM state encodings and response codes.
package mac_cfg_pkg;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StStartup = 3'd1;
    localparam logic [2:0] StWrReq   = 3'd2;
    localparam logic [2:0] StWrResp  = 3'd3;
    localparam logic [2:0] StRdReq   = 3'd4;
    localparam logic [2:0] StRdResp  = 3'd5;
    localparam logic [2:0] StDone    = 3'd6;
    localparam logic [2:0] StError   = 3'd7;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [11:0] ADDR_MDIO_CFG  = 12'h500;
    localparam logic [11:0] ADDR_RX_CFG    = 12'h404;
    localparam logic [11:0] ADDR_TX_CFG    = 12'h408;
    localparam logic [11:0] ADDR_FLOW_CTRL = 12'h40C;
    localparam logic [11:0] ADDR_SPEED_CFG = 12'h410;

    localparam logic [31:0] DATA_MDIO_CFG  = 32'h0000_0068;
    localparam logic [31:0] DATA_RX_CFG    = 32'h1000_0000;
    localparam logic [31:0] DATA_TX_CFG    = 32'h1000_0000;
    localparam logic [31:0] DATA_FLOW_CTRL = 32'h0000_0000;

    // Index of the speed write; the table is walked 0..LAST_IDX.
    localparam logic [2:0] LAST_IDX = 3'd4;

    function automatic logic [11:0] wr_addr(input logic [2:0] idx);
        logic [11:0] addr;
        case (idx)
            3'd0:    addr = ADDR_MDIO_CFG;
            3'd1:    addr = ADDR_RX_CFG;
            3'd2:    addr = ADDR_TX_CFG;
            3'd3:    addr = ADDR_FLOW_CTRL;
            default: addr = ADDR_SPEED_CFG;
        endcase
        return addr;
    endfunction

    function automatic logic [31:0] wr_data(input logic [2:0] idx, input logic [1:0] speed);
        logic [31:0] data;
        case (idx)
            3'd0:    data = DATA_MDIO_CFG;
            3'd1:    data = DATA_RX_CFG;
            3'd2:    data = DATA_TX_CFG;
            3'd3:    data = DATA_FLOW_CTRL;
            default: data = {speed, 30'b0};
        endcase
        return data;
    endfunction

endpackage

// File: rtl/syn_block.sv
// Two-flop synchronizer with enable; brings an asynchronous level into the clk domain.
module syn_block #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta <= '0;
            sync <= '0;
        end else if (en) begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;

endmodule

// File: rtl/mac_axil_config.sv
// Configures the Ethernet MAC over AXI-lite after PHY release, verifies the speed
// register by read-back, and re-programs it whenever speed_sel changes.
module mac_axil_config
    import mac_cfg_pkg::*;
#(
    parameter int unsigned STARTUP_CYCLES = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        s_axi_clk,
    input  logic        s_axi_resetn,
    input  logic        phy_resetn,
    input  logic [1:0]  speed_sel,
    output logic [11:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [11:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic        cfg_done,
    output logic        cfg_error
);

    localparam int unsigned SCW = $clog2(STARTUP_CYCLES + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SCW-1:0] STARTUP_LAST = SCW'(STARTUP_CYCLES - 1);
    localparam logic [TW-1:0]  TIMER_LAST   = TW'(TIMEOUT_CYCLES - 1);

    logic           phy_rel;
    logic [2:0]     state;
    logic [SCW-1:0] startup_cnt;
    logic [TW-1:0]  timer;
    logic [2:0]     idx;
    logic [2:0]     idx_next;
    logic [1:0]     speed_reg;
    logic           aw_done;
    logic           w_done;
    logic           aw_fire;
    logic           w_fire;
    logic           timed_out;
    logic           rd_match;
    logic           go_error;
    logic           unused_rdata;

    syn_block #(
        .WIDTH (1)
    ) u_phy_sync (
        .clk    (s_axi_clk),
        .resetn (s_axi_resetn),
        .en     (1'b1),
        .d      (phy_resetn),
        .q      (phy_rel)
    );

    assign aw_fire      = m_axi_awvalid & m_axi_awready;
    assign w_fire       = m_axi_wvalid & m_axi_wready;
    assign idx_next     = idx + 3'd1;
    assign timed_out    = (timer >= TIMER_LAST);
    assign rd_match     = (m_axi_rresp == RESP_OKAY) && (m_axi_rdata[31:30] == speed_reg);
    assign unused_rdata = ^m_axi_rdata[29:0];

    // A closing response in the same cycle as the last timer tick still wins.
    always_comb begin
        go_error = 1'b0;
        case (state)
            StWrReq:  go_error = timed_out;
            StWrResp: go_error = m_axi_bvalid ? (m_axi_bresp != RESP_OKAY) : timed_out;
            StRdReq:  go_error = timed_out;
            StRdResp: go_error = m_axi_rvalid ? !rd_match : timed_out;
            default:  go_error = 1'b0;
        endcase
    end

    always_ff @(posedge s_axi_clk) begin
        if (!s_axi_resetn) begin
            state         <= StIdle;
            startup_cnt   <= '0;
            timer         <= '0;
            idx           <= '0;
            speed_reg     <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            cfg_done      <= 1'b0;
            cfg_error     <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (phy_rel) begin
                        state       <= StStartup;
                        startup_cnt <= '0;
                    end
                end
                StStartup: begin
                    if (startup_cnt == STARTUP_LAST) begin
                        speed_reg     <= speed_sel;
                        idx           <= '0;
                        state         <= StWrReq;
                        timer         <= '0;
                        m_axi_awaddr  <= wr_addr(3'd0);
                        m_axi_wdata   <= wr_data(3'd0, speed_sel);
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                    end else begin
                        startup_cnt <= startup_cnt + 1'b1;
                    end
                end
                StWrReq: begin
                    timer <= timer + 1'b1;
                    if (aw_fire) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_fire) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        state        <= StWrResp;
                        m_axi_bready <= 1'b1;
                    end
                end
                StWrResp: begin
                    timer <= timer + 1'b1;
                    if (m_axi_bvalid && (m_axi_bresp == RESP_OKAY)) begin
                        m_axi_bready <= 1'b0;
                        timer        <= '0;
                        if (idx == LAST_IDX) begin
                            state         <= StRdReq;
                            m_axi_araddr  <= ADDR_SPEED_CFG;
                            m_axi_arvalid <= 1'b1;
                        end else begin
                            idx           <= idx_next;
                            state         <= StWrReq;
                            m_axi_awaddr  <= wr_addr(idx_next);
                            m_axi_wdata   <= wr_data(idx_next, speed_reg);
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                        end
                    end
                end
                StRdReq: begin
                    timer <= timer + 1'b1;
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= StRdResp;
                    end
                end
                StRdResp: begin
                    timer <= timer + 1'b1;
                    if (m_axi_rvalid && rd_match) begin
                        m_axi_rready <= 1'b0;
                        cfg_done     <= 1'b1;
                        state        <= StDone;
                    end
                end
                StDone: begin
                    if (!phy_rel) begin
                        state     <= StIdle;
                        cfg_done  <= 1'b0;
                        cfg_error <= 1'b0;
                    end else if (speed_sel != speed_reg) begin
                        // Only the speed register and its read-back are repeated.
                        speed_reg     <= speed_sel;
                        cfg_done      <= 1'b0;
                        idx           <= LAST_IDX;
                        state         <= StWrReq;
                        timer         <= '0;
                        m_axi_awaddr  <= ADDR_SPEED_CFG;
                        m_axi_wdata   <= {speed_sel, 30'b0};
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                    end
                end
                StError: begin
                    m_axi_awvalid <= 1'b0;
                    m_axi_wvalid  <= 1'b0;
                    m_axi_bready  <= 1'b0;
                    m_axi_arvalid <= 1'b0;
                    m_axi_rready  <= 1'b0;
                    if (!phy_rel) begin
                        state     <= StIdle;
                        cfg_done  <= 1'b0;
                        cfg_error <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase

            // Fault exit drops every handshake signal, even mid-transfer.
            if (go_error) begin
                state         <= StError;
                cfg_error     <= 1'b1;
                cfg_done      <= 1'b0;
                m_axi_awvalid <= 1'b0;
                m_axi_wvalid  <= 1'b0;
                m_axi_bready  <= 1'b0;
                m_axi_arvalid <= 1'b0;
                m_axi_rready  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_axil_config.sv
// Directed bench for mac_axil_config: a small AXI-lite slave model answers on the
// falling edge, and each scenario checks handshakes, write order and status flags.
module tb_mac_axil_config;

    localparam int unsigned STARTUP = 20;
    localparam int unsigned TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        resetn;
    logic        phy_resetn;
    logic [1:0]  speed_sel;
    logic [11:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [11:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        cfg_done;
    logic        cfg_error;

    // Slave model knobs and observation state.
    int          aw_delay;
    int          bad_b_idx;
    bit          ar_never;
    int          aw_cnt;
    int          n_aw, n_w, n_b, n_ar, n_r;
    int          aw_hi, w_hi, stab_err;
    int          cyc;
    int          ar_cyc, err_cyc;
    bit          pend_aw, pend_w, pend_r, b_fire, r_fire;
    bit          aw_wait, w_wait, ar_prev, err_prev;
    logic [11:0] aw_hold;
    logic [31:0] w_hold;
    logic [31:0] mem410;
    logic [31:0] last_rdata;
    logic [11:0] log_addr [16];
    logic [31:0] log_data [16];

    int n_assert = 0;
    int n_fail   = 0;

    logic [11:0] exp_addr [5];
    logic [31:0] exp_data [5];

    mac_axil_config #(
        .STARTUP_CYCLES (STARTUP),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .s_axi_clk     (clk),
        .s_axi_resetn  (resetn),
        .phy_resetn    (phy_resetn),
        .speed_sel     (speed_sel),
        .m_axi_awaddr  (awaddr),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready),
        .cfg_done      (cfg_done),
        .cfg_error     (cfg_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Slave responds on the falling edge; a handshake is logged when valid and
    // ready are both high here, since neither changes before the next rising edge.
    always @(negedge clk) begin
        if (!resetn) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
            rvalid = 0; rdata = 0; rresp = 0;
            aw_cnt = 0; n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
            aw_hi = 0; w_hi = 0; stab_err = 0; ar_cyc = 0; err_cyc = 0;
            pend_aw = 0; pend_w = 0; pend_r = 0; b_fire = 0; r_fire = 0;
            aw_wait = 0; w_wait = 0; ar_prev = 0; err_prev = 0;
            mem410 = 0; last_rdata = 0;
        end else begin
            if (b_fire) begin bvalid = 0; b_fire = 0; end
            if (r_fire) begin rvalid = 0; r_fire = 0; end
            if (!bvalid && pend_aw && pend_w) begin
                bresp = (n_b == bad_b_idx) ? 2'b10 : 2'b00;
                if (n_b < 16 && log_addr[n_b] == 12'h410) mem410 = log_data[n_b];
                bvalid = 1; pend_aw = 0; pend_w = 0;
            end
            if (!rvalid && pend_r) begin
                rvalid = 1; rdata = mem410; rresp = 2'b00; pend_r = 0;
            end
            if (bvalid && bready) begin b_fire = 1; n_b++; end
            if (rvalid && rready) begin r_fire = 1; n_r++; last_rdata = rdata; end

            if (aw_wait && !(awvalid && awaddr == aw_hold)) stab_err++;
            if (w_wait && !(wvalid && wdata == w_hold)) stab_err++;
            aw_hi += int'(awvalid);
            w_hi  += int'(wvalid);

            if (awvalid) begin
                if (aw_cnt >= aw_delay) awready = 1;
                else begin awready = 0; aw_cnt++; end
            end else begin
                awready = 0; aw_cnt = 0;
            end
            wready = wvalid;
            if (awvalid && awready) begin
                if (n_aw < 16) log_addr[n_aw] = awaddr;
                n_aw++; pend_aw = 1; aw_wait = 0;
            end else begin
                aw_wait = awvalid; aw_hold = awaddr;
            end
            if (wvalid && wready) begin
                if (n_w < 16) log_data[n_w] = wdata;
                n_w++; pend_w = 1; w_wait = 0;
            end else begin
                w_wait = wvalid; w_hold = wdata;
            end

            arready = arvalid && !ar_never;
            if (arvalid && arready) begin n_ar++; pend_r = 1; end
            if (arvalid && !ar_prev) ar_cyc = cyc;
            if (cfg_error && !err_prev) err_cyc = cyc;
            ar_prev  = arvalid;
            err_prev = cfg_error;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_pulse(input int cycles);
        @(negedge clk); #1;
        resetn = 1'b0;
        repeat (cycles) @(negedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic wait_flag(input int which, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk); #1;
            if (which == 0 && cfg_done) break;
            if (which == 1 && cfg_error) break;
        end
    endtask

    int rel_cyc;
    int seen_b;
    int seen_r;

    initial begin
        exp_addr[0] = 12'h500; exp_data[0] = 32'h0000_0068;
        exp_addr[1] = 12'h404; exp_data[1] = 32'h1000_0000;
        exp_addr[2] = 12'h408; exp_data[2] = 32'h1000_0000;
        exp_addr[3] = 12'h40C; exp_data[3] = 32'h0000_0000;
        exp_addr[4] = 12'h410; exp_data[4] = 32'h8000_0000;
        cyc = 0; aw_delay = 0; bad_b_idx = -1; ar_never = 0;
        resetn = 1'b0; phy_resetn = 1'b0; speed_sel = 2'b10;

        // Reset state and IDLE hold while the PHY is still in reset.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        chk("rst_flags", {cfg_done, cfg_error}, 2'b0);
        chk("rst_addr", {awaddr, araddr}, 24'h0);
        chk("rst_wdata", wdata, 32'h0);
        resetn = 1'b1;
        repeat (STARTUP + 10) @(negedge clk);
        #1;
        chk("idle_hold", {awvalid, cfg_done}, 2'b0);

        // Zero-wait slave, 1G.
        phy_resetn = 1'b1;
        wait_flag(0, 2000);
        chk("zw_done", cfg_done, 1'b1);
        chk("zw_error", cfg_error, 1'b0);
        chk("zw_n_aw", n_aw, 5);
        chk("zw_n_b", n_b, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("zw_addr%0d", i), log_addr[i], exp_addr[i]);
            chk($sformatf("zw_data%0d", i), log_data[i], exp_data[i]);
        end
        chk("zw_n_r", n_r, 1);
        chk("zw_rdata", last_rdata, 32'h8000_0000);
        chk("zw_araddr", araddr, 12'h410);

        // Speed change 10 -> 01 while DONE.
        seen_b = n_b; seen_r = n_r;
        speed_sel = 2'b01;
        @(negedge clk); #1;
        chk("sp_done_low", cfg_done, 1'b0);
        wait_flag(0, 500);
        chk("sp_done", cfg_done, 1'b1);
        chk("sp_n_aw", n_aw, 6);
        chk("sp_addr", log_addr[5], 12'h410);
        chk("sp_data", log_data[5], 32'h4000_0000);
        chk("sp_one_b", n_b - seen_b, 1);
        chk("sp_one_r", n_r - seen_r, 1);

        // PHY back into reset while DONE clears the flags.
        phy_resetn = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("phy_drop_flags", {cfg_done, cfg_error}, 2'b0);

        // awready delayed 3 cycles, wready immediate.
        speed_sel = 2'b10; aw_delay = 3;
        reset_pulse(3);
        phy_resetn = 1'b1;
        wait_flag(0, 2000);
        chk("dly_done", cfg_done, 1'b1);
        chk("dly_n_b", n_b, 5);
        chk("dly_w_hi", w_hi, 5);
        chk("dly_aw_hi", aw_hi, 20);
        chk("dly_stable", stab_err, 0);

        // Error response on the 0x404 write.
        aw_delay = 0; bad_b_idx = 1;
        reset_pulse(3);
        wait_flag(1, 2000);
        chk("br_error", cfg_error, 1'b1);
        chk("br_done", cfg_done, 1'b0);
        repeat (50) @(negedge clk);
        #1;
        chk("br_n_aw", n_aw, 2);
        chk("br_addr1", log_addr[1], 12'h404);
        chk("br_quiet", {awvalid, wvalid, bready}, 3'b0);

        // Slave never accepts the read address.
        bad_b_idx = -1; ar_never = 1;
        reset_pulse(3);
        wait_flag(1, 3000);
        chk("to_error", cfg_error, 1'b1);
        chk("to_latency", err_cyc - ar_cyc, TIMEOUT);
        chk("to_arvalid", arvalid, 1'b0);
        chk("to_n_b", n_b, 5);

        // Reset pulse in the middle of the 0x408 write.
        ar_never = 0;
        reset_pulse(3);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if (awvalid && awaddr == 12'h408) break;
        end
        chk("mr_at_408", {awvalid, awaddr}, {1'b1, 12'h408});
        resetn = 1'b0;
        @(negedge clk); #1;
        chk("mr_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        chk("mr_flags", {cfg_done, cfg_error}, 2'b0);
        chk("mr_addr", {awaddr, araddr}, 24'h0);
        chk("mr_wdata", wdata, 32'h0);
        resetn = 1'b1;
        rel_cyc = cyc;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (awvalid) break;
        end
        chk("mr_restart_addr", {awvalid, awaddr}, {1'b1, 12'h500});
        chk("mr_startup_wait", (cyc - rel_cyc >= STARTUP) && (cyc - rel_cyc <= STARTUP + 4), 1'b1);
        wait_flag(0, 2000);
        chk("mr_done", cfg_done, 1'b1);
        chk("mr_n_aw", n_aw, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
